alu_loader: RTL and testbench

Command-driven initiator for the ALU top-level load interface. Accepts one operation (operand A, operand B, opcode) per valid/ready handshake and replays the three-step register-load sequence on the shared data bus and enables. It then waits a settle interval, captures the ALU result, carry and zero flags, and returns them as a response under valid/ready. It sits between a host/controller and the ALU top, in place of the switches and buttons.

---
 rtl/alu_loader.sv | 218 +++++++++++++++++++++
 tb/tb_alu_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_loader.sv
// alu_loader: command-driven initiator that replays the three-step register
// load sequence into an ALU top, waits for the result to settle, captures it
// and returns it as a valid/ready response.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a command; o_cmd_ready high
// LOAD_A   | operand A on the bus, o_enable_1 pulsed
// GAP_A    | enables low, A held on the bus
// LOAD_B   | operand B on the bus, o_enable_2 pulsed
// GAP_B    | enables low, B held on the bus
// LOAD_OP  | opcode (MSB-aligned) on the bus, o_enable_3 pulsed
// GAP_OP   | enables low, opcode held on the bus
// SETTLE   | settle down-counter running; capture on terminal count
// RESP     | response valid, held until i_rsp_ready
//
// NB_OP must not exceed NB_DATA and SETTLE_CYCLES must be at least 1.
module alu_loader #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [NB_DATA-1:0] i_cmd_a,
  input  logic [NB_DATA-1:0] i_cmd_b,
  input  logic [NB_OP-1:0]   i_cmd_op,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_enable_1,
  output logic               o_enable_2,
  output logic               o_enable_3,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [NB_DATA-1:0] o_rsp_result,
  output logic               o_rsp_carry,
  output logic               o_rsp_zero
);

  // The counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int NB_CNT = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_GAP_A,
    ST_LOAD_B,
    ST_GAP_B,
    ST_LOAD_OP,
    ST_GAP_OP,
    ST_SETTLE,
    ST_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [NB_DATA-1:0]  r_a;
  logic [NB_DATA-1:0]  r_b;
  logic [NB_OP-1:0]    r_op;
  logic [NB_CNT-1:0]   r_settle_cnt;
  logic [NB_DATA-1:0]  r_data;
  logic                r_enable_1;
  logic                r_enable_2;
  logic                r_enable_3;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [NB_DATA-1:0]  r_rsp_result;
  logic                r_rsp_carry;
  logic                r_rsp_zero;

  logic [NB_CNT-1:0]   w_next_cnt;
  logic [NB_DATA-1:0]  w_next_data;
  logic                w_next_enable_1;
  logic                w_next_enable_2;
  logic                w_next_enable_3;
  logic                w_next_cmd_ready;
  logic                w_next_rsp_valid;
  logic                w_load_cmd;
  logic                w_capture;
  logic [NB_DATA-1:0]  w_op_bus;

  // Opcode sits in the bus MSBs with the low bits zero.
  assign w_op_bus = NB_DATA'(r_op) << (NB_DATA - NB_OP);

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_next_state     = r_state;
    w_next_cnt       = r_settle_cnt;
    w_next_data      = r_data;
    w_next_enable_1  = 1'b0;
    w_next_enable_2  = 1'b0;
    w_next_enable_3  = 1'b0;
    w_next_cmd_ready = 1'b0;
    w_next_rsp_valid = r_rsp_valid;
    w_load_cmd       = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next_cmd_ready = 1'b1;
        if (i_cmd_valid && r_cmd_ready) begin
          w_load_cmd       = 1'b1;
          w_next_state     = ST_LOAD_A;
          w_next_data      = i_cmd_a;
          w_next_enable_1  = 1'b1;
          w_next_cmd_ready = 1'b0;
        end
      end
      ST_LOAD_A: begin
        w_next_state = ST_GAP_A;
      end
      ST_GAP_A: begin
        w_next_state    = ST_LOAD_B;
        w_next_data     = r_b;
        w_next_enable_2 = 1'b1;
      end
      ST_LOAD_B: begin
        w_next_state = ST_GAP_B;
      end
      ST_GAP_B: begin
        w_next_state    = ST_LOAD_OP;
        w_next_data     = w_op_bus;
        w_next_enable_3 = 1'b1;
      end
      ST_LOAD_OP: begin
        w_next_state = ST_GAP_OP;
      end
      ST_GAP_OP: begin
        w_next_state = ST_SETTLE;
        w_next_cnt   = CNT_LOAD;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == '0) begin
          w_capture        = 1'b1;
          w_next_state     = ST_RESP;
          w_next_rsp_valid = 1'b1;
        end else begin
          w_next_cnt = r_settle_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_next_state     = ST_IDLE;
          w_next_rsp_valid = 1'b0;
          w_next_cmd_ready = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, bus, strobes, handshake flags and settle counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_data       <= '0;
      r_enable_1   <= 1'b0;
      r_enable_2   <= 1'b0;
      r_enable_3   <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_settle_cnt <= w_next_cnt;
      r_data       <= w_next_data;
      r_enable_1   <= w_next_enable_1;
      r_enable_2   <= w_next_enable_2;
      r_enable_3   <= w_next_enable_3;
      r_cmd_ready  <= w_next_cmd_ready;
      r_rsp_valid  <= w_next_rsp_valid;
    end
  end

  // Command capture on accept so later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_load_cmd) begin
      r_a  <= i_cmd_a;
      r_b  <= i_cmd_b;
      r_op <= i_cmd_op;
    end
  end

  // Response capture at terminal count; fields then hold until the next capture.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
    end else if (w_capture) begin
      r_rsp_result <= i_alu_result;
      r_rsp_carry  <= i_alu_carry;
      r_rsp_zero   <= i_alu_zero;
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_data       = r_data;
  assign o_enable_1   = r_enable_1;
  assign o_enable_2   = r_enable_2;
  assign o_enable_3   = r_enable_3;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_carry  = r_rsp_carry;
  assign o_rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_loader.sv
// Directed bench for alu_loader with a small behavioural ALU top attached.
module tb_alu_loader;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_AND = 6'b100100;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [5:0] cmd_op;
  logic [7:0] bus;
  logic       en1;
  logic       en2;
  logic       en3;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;

  int n_checks = 0;
  int n_errors = 0;

  alu_loader dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_a      (cmd_a),
    .i_cmd_b      (cmd_b),
    .i_cmd_op     (cmd_op),
    .o_data       (bus),
    .o_enable_1   (en1),
    .o_enable_2   (en2),
    .o_enable_3   (en3),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry),
    .i_alu_zero   (alu_zero),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_carry  (rsp_carry),
    .o_rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU top stand-in: three load registers and a combinational result.
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [8:0] alu_sum;

  always_ff @(posedge clk) begin
    if (en1) alu_a <= bus;
    if (en2) alu_b <= bus;
    if (en3) alu_op <= bus[7:2];
  end

  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_result = alu_sum[7:0];
        alu_carry  = alu_sum[8];
      end
      OP_AND: alu_result = alu_a & alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
  endtask

  // Follows one command from its accept edge (next posedge) through the response.
  task automatic follow(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opbus,
                        input logic [7:0] res, input logic c, input logic z, input logic rdy);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a     = ~a;
    cmd_b     = ~b;
    cmd_op    = 6'h3f;
    chk("load_a_en", {en3, en2, en1}, 3'b001);
    chk("load_a_data", bus, a);
    chk("load_a_ready", cmd_ready, 1'b0);
    @(negedge clk);
    chk("gap_a_en", {en3, en2, en1}, 3'b000);
    chk("gap_a_data", bus, a);
    @(negedge clk);
    chk("load_b_en", {en3, en2, en1}, 3'b010);
    chk("load_b_data", bus, b);
    @(negedge clk);
    chk("gap_b_en", {en3, en2, en1}, 3'b000);
    chk("gap_b_data", bus, b);
    @(negedge clk);
    chk("load_op_en", {en3, en2, en1}, 3'b100);
    chk("load_op_data", bus, opbus);
    @(negedge clk);
    chk("gap_op_en", {en3, en2, en1}, 3'b000);
    chk("gap_op_data", bus, opbus);
    @(negedge clk);
    chk("settle_valid", rsp_valid, 1'b0);
    chk("settle_en", {en3, en2, en1}, 3'b000);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_result", rsp_result, res);
    chk("rsp_carry", rsp_carry, c);
    chk("rsp_zero", rsp_zero, z);
    chk("rsp_cmd_ready", cmd_ready, 1'b0);
    if (rdy) begin
      @(negedge clk);
      chk("post_rsp_valid", rsp_valid, 1'b0);
      chk("post_rsp_ready", cmd_ready, 1'b1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    issue(8'h33, 8'h44, OP_ADD);

    // Reset held two cycles with a command pending.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", cmd_ready, 1'b0);
      chk("rst_en", {en3, en2, en1}, 3'b000);
      chk("rst_data", bus, 8'h00);
      chk("rst_valid", rsp_valid, 1'b0);
      chk("rst_fields", {rsp_result, rsp_carry, rsp_zero}, 10'h000);
    end
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rel_ready", cmd_ready, 1'b1);
    chk("rel_en", {en3, en2, en1}, 3'b000);

    // Basic sequence and the overflow / AND cases, ready held high.
    rsp_ready = 1'b1;
    issue(8'd15, 8'd10, OP_ADD);
    follow(8'd15, 8'd10, 8'h80, 8'd25, 1'b0, 1'b0, 1'b1);
    issue(8'd200, 8'd100, OP_ADD);
    follow(8'd200, 8'd100, 8'h80, 8'd44, 1'b1, 1'b0, 1'b1);
    issue(8'd128, 8'd128, OP_ADD);
    follow(8'd128, 8'd128, 8'h80, 8'd0, 1'b1, 1'b1, 1'b1);
    issue(8'hAA, 8'h55, OP_AND);
    follow(8'hAA, 8'h55, 8'h90, 8'h00, 1'b0, 1'b1, 1'b1);
    issue(8'hFF, 8'h0F, OP_AND);
    follow(8'hFF, 8'h0F, 8'h90, 8'h0F, 1'b0, 1'b0, 1'b1);

    // Backpressure with new commands presented throughout.
    rsp_ready = 1'b0;
    issue(8'd3, 8'd4, OP_ADD);
    follow(8'd3, 8'd4, 8'h80, 8'd7, 1'b0, 1'b0, 1'b0);
    issue(8'd1, 8'd1, OP_ADD);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_result", rsp_result, 8'd7);
      chk("bp_flags", {rsp_carry, rsp_zero}, 2'b00);
      chk("bp_ready", cmd_ready, 1'b0);
      chk("bp_en", {en3, en2, en1}, 3'b000);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1'b0);
    chk("bp_release_ready", cmd_ready, 1'b1);
    follow(8'd1, 8'd1, 8'h80, 8'd2, 1'b0, 1'b0, 1'b1);

    // Reset during LOAD_B aborts the command.
    issue(8'h10, 8'h20, OP_ADD);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort_load_a", {en3, en2, en1}, 3'b001);
    @(negedge clk);
    @(negedge clk);
    chk("abort_load_b", {en3, en2, en1}, 3'b010);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_en", {en3, en2, en1}, 3'b000);
    chk("abort_data", bus, 8'h00);
    chk("abort_valid", rsp_valid, 1'b0);
    chk("abort_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 1'b0);
      chk("abort_no_en", {en3, en2, en1}, 3'b000);
    end
    chk("abort_ready_back", cmd_ready, 1'b1);
    issue(8'h21, 8'h12, OP_ADD);
    follow(8'h21, 8'h12, 8'h80, 8'h33, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
